highpass_biquad_scheduler: RTL and testbench

- Stereo high-pass stage for the channel strip: one shared multiplier/accumulator, time-multiplexed across 5 biquad taps and 2 channels (L, R).
- Replaces two free-running per-channel biquads.
- Starts on a per-sample strobe from the codec interface. Sequences coefficient fetch, MAC, clip and history update, then presents both outputs together with a valid pulse.
- Filter-select changes take effect only at sample boundaries, with history flushed.

---
 rtl/highpass_biquad_scheduler_pkg.sv | 30 +++
 rtl/highpass_biquad_scheduler_if.sv | 26 ++
 rtl/highpass_biquad_scheduler_coeff_rom.sv | 26 ++
 rtl/highpass_biquad_scheduler.sv | 166 ++++++++++++++++
 tb/tb_highpass_biquad_scheduler.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/highpass_biquad_scheduler_pkg.sv
// Purpose: shared constants, state encoding and Q30 coefficient table for the stereo high-pass scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package highpass_biquad_scheduler_pkg;

    localparam int NUM_TAPS    = 5;
    localparam int NUM_FILTERS = 5;

    // Output clip limits for the 16-bit sample path.
    localparam int CLIP_MAX = 32767;
    localparam int CLIP_MIN = -32768;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_WB,
        ST_DONE
    } state_t;

    // Rows: allpass, 100 Hz, 250 Hz, 500 Hz, 1 kHz. Columns: b0, b1, b2, a1, a2.
    // Values are pre-scaled by 2**30; a1/a2 carry the feedback sign so every tap adds.
    localparam int COEF_TABLE [NUM_FILTERS][NUM_TAPS] = '{
        '{ 1073741824,           0,          0,          0,           0 },
        '{ 1063911424, -2127822848, 1063911424, 2127298560, -1054081024 },
        '{ 1049100288, -2098200576, 1049100288, 2097807360, -1024065536 },
        '{ 1025769472, -2051538944, 1025769472, 2048917504,  -975503360 },
        '{  981467136, -1962934272,  981467136, 1946157056,  -889192448 }
    };

endpackage

// File: rtl/highpass_biquad_scheduler_if.sv
// Purpose: sample-strobe in / stereo result out bundle between codec side and the high-pass scheduler.
// Latency: n/a (wires only).
// Backpressure: none; overrun reports strobes that arrive while the scheduler is busy.
interface highpass_biquad_scheduler_if;

    logic               sample_valid;
    logic [2:0]         filter;
    logic signed [15:0] in_l;
    logic signed [15:0] in_r;
    logic signed [15:0] out_l;
    logic signed [15:0] out_r;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    modport master (
        output sample_valid, filter, in_l, in_r,
        input  out_l, out_r, out_valid, busy, overrun
    );

    modport slave (
        input  sample_valid, filter, in_l, in_r,
        output out_l, out_r, out_valid, busy, overrun
    );

endinterface

// File: rtl/highpass_biquad_scheduler_coeff_rom.sv
// Purpose: constant coefficient lookup by (filter, tap); unknown filters fall back to allpass.
// Latency: combinational.
// Backpressure: none.
module hp_coeff_rom
    import highpass_biquad_scheduler_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic [2:0]           filter,
    input  logic [2:0]           tap,
    output logic signed [CW-1:0] coef
);

    // Table lookup; taps past the last one read as zero.
    always_comb begin
        coef = '0;
        if (int'(tap) < NUM_TAPS) begin
            if (int'(filter) < NUM_FILTERS) begin
                coef = CW'(COEF_TABLE[filter][tap]);
            end else begin
                coef = CW'(COEF_TABLE[0][tap]);
            end
        end
    end

endmodule

// File: rtl/highpass_biquad_scheduler.sv
// Purpose: stereo biquad high-pass sharing one MAC across 5 taps x 2 channels.
// Latency: out_valid 13 cycles after the accepted sample_valid; next sample accepted from the DONE cycle on.
// Backpressure: none; strobes during MAC/WB are dropped and flagged on overrun in the same cycle.
module highpass_biquad_scheduler
    import highpass_biquad_scheduler_pkg::*;
#(
    parameter int SHIFT = 30,
    parameter int CW    = 32,
    parameter int DW    = 32,
    parameter int AW    = 40
) (
    input  logic                        clk_48,
    input  logic                        reset_n,
    highpass_biquad_scheduler_if.slave  bus
);

    localparam logic signed [AW-1:0] ACC_MAX = AW'({1'b0, {(DW-1){1'b1}}});
    localparam logic signed [AW-1:0] ACC_MIN = ~ACC_MAX;

    state_t                state;
    logic                  ch;
    logic [2:0]            tap;
    logic [2:0]            filt_lat;
    logic [2:0]            filt_in;
    logic signed [15:0]    x0_l;
    logic signed [15:0]    x0_r;
    logic signed [DW-1:0]  x1_h [2];
    logic signed [DW-1:0]  x2_h [2];
    logic signed [DW-1:0]  y1_h [2];
    logic signed [DW-1:0]  y2_h [2];
    logic signed [AW-1:0]  acc;
    logic signed [AW-1:0]  acc_base;
    logic signed [AW-1:0]  prod_sh;
    logic signed [CW-1:0]  coef;
    logic signed [DW-1:0]  operand;
    logic signed [CW+DW-1:0] prod_full;
    logic signed [DW-1:0]  y_sat;
    logic signed [15:0]    y_clip;

    hp_coeff_rom #(.CW(CW)) u_rom (
        .filter (filt_lat),
        .tap    (tap),
        .coef   (coef)
    );

    // Out-of-range selects behave as allpass.
    assign filt_in = (bus.filter > 3'd4) ? 3'd0 : bus.filter;

    // Strobes that land mid-sample are reported immediately and otherwise dropped.
    assign bus.overrun = bus.sample_valid && ((state == ST_MAC) || (state == ST_WB));

    // Pick the history/input word that pairs with the current tap.
    always_comb begin
        operand = '0;
        case (tap)
            3'd0:    operand = DW'(ch ? x0_r : x0_l);
            3'd1:    operand = x1_h[ch];
            3'd2:    operand = x2_h[ch];
            3'd3:    operand = y1_h[ch];
            3'd4:    operand = y2_h[ch];
            default: operand = '0;
        endcase
    end

    // Full-width product, floor-shifted back to integer scale; tap 0 restarts the sum.
    assign prod_full = (CW+DW)'(coef) * (CW+DW)'(operand);
    assign prod_sh   = AW'(prod_full >>> SHIFT);
    assign acc_base  = (tap == 3'd0) ? '0 : acc;

    // Saturate the sum to history width, then clip to the 16-bit output range.
    always_comb begin
        y_sat = acc[DW-1:0];
        if (acc > ACC_MAX) begin
            y_sat = ACC_MAX[DW-1:0];
        end else if (acc < ACC_MIN) begin
            y_sat = ACC_MIN[DW-1:0];
        end
        y_clip = y_sat[15:0];
        if (y_sat > DW'(CLIP_MAX)) begin
            y_clip = 16'(CLIP_MAX);
        end else if (y_sat < DW'(CLIP_MIN)) begin
            y_clip = 16'(CLIP_MIN);
        end
    end

    // Sequencer: accept, MAC L, write back L, MAC R, write back R, publish.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            ch            <= 1'b0;
            tap           <= '0;
            filt_lat      <= '0;
            x0_l          <= '0;
            x0_r          <= '0;
            acc           <= '0;
            bus.out_l     <= '0;
            bus.out_r     <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                x1_h[i] <= '0;
                x2_h[i] <= '0;
                y1_h[i] <= '0;
                y2_h[i] <= '0;
            end
        end else begin
            bus.out_valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.sample_valid) begin
                        x0_l     <= bus.in_l;
                        x0_r     <= bus.in_r;
                        filt_lat <= filt_in;
                        ch       <= 1'b0;
                        tap      <= '0;
                        bus.busy <= 1'b1;
                        state    <= ST_MAC;
                        // A new corner must not see state built up by the old one.
                        if (filt_in != filt_lat) begin
                            for (int i = 0; i < 2; i++) begin
                                x1_h[i] <= '0;
                                x2_h[i] <= '0;
                                y1_h[i] <= '0;
                                y2_h[i] <= '0;
                            end
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_MAC: begin
                    acc <= acc_base + prod_sh;
                    if (tap == 3'(NUM_TAPS - 1)) begin
                        state <= ST_WB;
                    end else begin
                        tap <= tap + 3'd1;
                    end
                end
                ST_WB: begin
                    x2_h[ch] <= x1_h[ch];
                    x1_h[ch] <= operand_x0(ch);
                    y2_h[ch] <= y1_h[ch];
                    y1_h[ch] <= y_sat;
                    if (!ch) begin
                        bus.out_l <= y_clip;
                        ch        <= 1'b1;
                        tap       <= '0;
                        state     <= ST_MAC;
                    end else begin
                        bus.out_r     <= y_clip;
                        bus.out_valid <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Latched input sample of the given channel, widened to history width.
    function automatic logic signed [DW-1:0] operand_x0(input logic sel_r);
        return DW'(sel_r ? x0_r : x0_l);
    endfunction

endmodule

// File: tb/tb_highpass_biquad_scheduler.sv
module tb_highpass_biquad_scheduler;

    logic clk_48 = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_c0 = -100;

    highpass_biquad_scheduler_if hp_bus ();

    highpass_biquad_scheduler dut (
        .clk_48  (clk_48),
        .reset_n (reset_n),
        .bus     (hp_bus)
    );

    always #5 clk_48 = ~clk_48;
    always @(posedge clk_48) cyc <= cyc + 1;

    typedef struct {
        int l;
        int r;
        int due;
    } exp_t;
    exp_t sb[$];

    // Corner table in units of 1/16384; highpass form b1 = -2*b0, b2 = b0.
    localparam int B0_N [5] = '{16384, 16234, 16008, 15652, 14976};
    localparam int A1_N [5] = '{0, 32460, 32010, 31264, 29696};
    localparam int A2_N [5] = '{0, -16084, -15626, -14885, -13568};

    longint hx1 [2];
    longint hx2 [2];
    longint hy1 [2];
    longint hy2 [2];
    int     m_filt = 0;

    function automatic longint coef_of(input int f, input int t);
        longint b0;
        if (f == 0) return (t == 0) ? (64'sd1 <<< 30) : 64'sd0;
        b0 = longint'(B0_N[f]) * 64'sd65536;
        case (t)
            0:       return b0;
            1:       return -2 * b0;
            2:       return b0;
            3:       return longint'(A1_N[f]) * 64'sd65536;
            default: return longint'(A2_N[f]) * 64'sd65536;
        endcase
    endfunction

    function automatic longint floor_q30(input longint p);
        longint d;
        d = 64'sd1 <<< 30;
        if (p >= 0) return p / d;
        return -((-p + d - 1) / d);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            hx1[i] = 0; hx2[i] = 0; hy1[i] = 0; hy2[i] = 0;
        end
    endtask

    task automatic model(input int f, input int l, input int r, output int ol, output int orr);
        int fe;
        longint x0, acc, y, o;
        int outs [2];
        fe = (f > 4) ? 0 : f;
        if (fe != m_filt) clear_model();
        m_filt = fe;
        for (int c = 0; c < 2; c++) begin
            x0 = (c == 0) ? longint'(l) : longint'(r);
            acc = floor_q30(coef_of(fe, 0) * x0) + floor_q30(coef_of(fe, 1) * hx1[c])
                + floor_q30(coef_of(fe, 2) * hx2[c]) + floor_q30(coef_of(fe, 3) * hy1[c])
                + floor_q30(coef_of(fe, 4) * hy2[c]);
            y = acc;
            if (y > 64'sd2147483647) y = 64'sd2147483647;
            if (y < -64'sd2147483648) y = -64'sd2147483648;
            hx2[c] = hx1[c]; hx1[c] = x0;
            hy2[c] = hy1[c]; hy1[c] = y;
            o = (y > 32767) ? 64'sd32767 : ((y < -32768) ? -64'sd32768 : y);
            outs[c] = int'(o);
        end
        ol  = outs[0];
        orr = outs[1];
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Called #1 after a rising edge; leaves #1 after the next rising edge.
    task automatic strobe(input int f, input int l, input int r,
                          input bit fixed, input int fl, input int fr);
        int c;
        bit accepted;
        int el, er;
        hp_bus.filter       = 3'(f);
        hp_bus.in_l         = 16'(l);
        hp_bus.in_r         = 16'(r);
        hp_bus.sample_valid = 1'b1;
        c = cyc;
        accepted = !((c >= last_c0 + 1) && (c <= last_c0 + 12));
        if (accepted) begin
            model(f, l, r, el, er);
            last_c0 = c;
            if (fixed) begin
                el = fl;
                er = fr;
            end
            sb.push_back('{el, er, c + 13});
        end
        @(negedge clk_48);
        check("overrun", longint'(hp_bus.overrun), longint'(!accepted));
        @(posedge clk_48);
        #1;
        hp_bus.sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_48);
            #1;
        end
    endtask

    // Scoreboard monitor: every out_valid must match the oldest expected result and its due cycle.
    always @(negedge clk_48) begin
        if (reset_n === 1'b1 && hp_bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got out_valid at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_l", longint'(hp_bus.out_l), longint'(e.l));
                check("out_r", longint'(hp_bus.out_r), longint'(e.r));
                check("latency", longint'(cyc), longint'(e.due));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rf, k, extra;
        hp_bus.sample_valid = 1'b0;
        hp_bus.filter       = 3'd0;
        hp_bus.in_l         = '0;
        hp_bus.in_r         = '0;
        reset_n             = 1'b0;
        clear_model();
        repeat (3) @(posedge clk_48);
        #1;
        reset_n = 1'b1;

        // Reset state.
        check("rst_out_l", longint'(hp_bus.out_l), 0);
        check("rst_out_r", longint'(hp_bus.out_r), 0);
        check("rst_out_valid", longint'(hp_bus.out_valid), 0);
        check("rst_busy", longint'(hp_bus.busy), 0);
        check("rst_overrun", longint'(hp_bus.overrun), 0);
        idle(1);

        // Allpass passthrough and busy window.
        strobe(0, 1000, -1000, 1'b1, 1000, -1000);
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk_48);
            check("busy", longint'(hp_bus.busy), longint'(i <= 12));
            @(posedge clk_48);
            #1;
        end

        // 1 kHz impulse response at a 48-cycle period.
        strobe(4, 16384, 0, 1'b1, 14976, 0);
        idle(47);
        strobe(4, 0, 0, 1'b1, -2808, 0);
        idle(47);
        repeat (4) begin
            strobe(4, 0, 0, 1'b0, 0, 0);
            idle(47);
        end

        // Corner change flushes history.
        strobe(0, 32767, 0, 1'b1, 32767, 0);
        idle(13);
        strobe(1, 32767, 0, 1'b1, 32467, 0);
        idle(13);
        repeat (4) begin
            strobe(1, 32767, 0, 1'b0, 0, 0);
            idle(13);
        end

        // Overrun at cycle 5 is dropped.
        strobe(0, 1000, -1000, 1'b1, 1000, -1000);
        idle(4);
        strobe(3, 5, 5, 1'b0, 0, 0);
        idle(8);

        // Nyquist full-scale drive forces clipping.
        for (int i = 0; i < 12; i++) begin
            strobe(4, (i % 2 == 0) ? 32767 : -32767, (i % 2 == 0) ? -32767 : 32767, 1'b0, 0, 0);
            idle(13);
        end

        // Randomized samples, corners and overrun strobes.
        rf = 4;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) rf = int'($urandom_range(0, 7));
            extra = int'($urandom_range(0, 6));
            strobe(rf, rnd16(), rnd16(), 1'b0, 0, 0);
            if ($urandom_range(0, 4) == 0) begin
                k = int'($urandom_range(1, 12));
                idle(k - 1);
                strobe(int'($urandom_range(0, 7)), rnd16(), rnd16(), 1'b0, 0, 0);
                idle(13 - k + extra);
            end else begin
                idle(13 + extra);
            end
        end

        // Reset in the middle of a sample aborts it.
        strobe(2, 20000, -20000, 1'b0, 0, 0);
        idle(7);
        reset_n = 1'b0;
        #1;
        check("abort_out_l", longint'(hp_bus.out_l), 0);
        check("abort_out_r", longint'(hp_bus.out_r), 0);
        check("abort_busy", longint'(hp_bus.busy), 0);
        check("abort_out_valid", longint'(hp_bus.out_valid), 0);
        sb.delete();
        clear_model();
        m_filt  = 0;
        last_c0 = -100;
        @(posedge clk_48);
        #1;
        reset_n = 1'b1;
        idle(2);
        strobe(2, 12345, -321, 1'b0, 0, 0);
        idle(13);
        strobe(2, -7000, 9000, 1'b0, 0, 0);
        idle(20);

        check("scoreboard_drained", longint'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
